mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Shares the core's single external memory port between the instruction cache (line refills) and the data cache (line refills and dirty-line writebacks). It sits below both caches and above the memory model, alongside the decode/execute/memory stage glue. It serialises whole-line transactions, alternates between requesters under contention, and routes read beats back to the owning cache.

## Interface
- LINE_WORDS, 4, words per cache line / burst length; power of two, ≥ 2
- DATA_WIDTH, 32, width of one memory beat
- clk  in  1  core clock
- rst  in  1  reset; synchronous, active-high
- i_req_valid  in  1  I-cache refill request; held until i_req_ready
- i_req_addr  in  `ADDR_WIDTH  line-aligned refill address
- i_req_ready  out  1  one-cycle pulse: I command accepted by memory
- i_rdata_valid / i_rdata / i_rdata_last  out  1/DATA_WIDTH/1  refill beat to I-cache
- d_req_valid  in  1  D-cache request; held until d_req_ready
- d_req_we  in  1  1 = writeback, 0 = refill
- d_req_addr  in  `ADDR_WIDTH  line-aligned address
- d_req_ready  out  1  one-cycle pulse: D command accepted
- d_wdata  in  DATA_WIDTH  current writeback word
- d_wdata_ready  out  1  D-cache advances to the next word on this
- d_wr_done  out  1  pulse on the last accepted write beat
- d_rdata_valid / d_rdata / d_rdata_last  out  1/DATA_WIDTH/1  refill beat to D-cache
- mem_cmd_valid / mem_cmd_we / mem_cmd_addr  out  1/1/`ADDR_WIDTH  memory command
- mem_cmd_ready  in  1  memory accepts the command
- mem_wdata_valid / mem_wdata  out  1/DATA_WIDTH  write beat
- mem_wdata_ready  in  1  memory accepts the write beat
- mem_rdata_valid / mem_rdata  in  1/DATA_WIDTH  read beat from memory
- perf_i_wait / perf_d_wait  out  32/32  stall counters; present only with MEM_ARB_PERF_EN

## Operation
- FSM states: IDLE, CMD, RDATA, WDATA.
- IDLE, arbitration:
  - One requester valid: grant it.
  - Both valid: grant the one not granted last (last_grant register).
  - On grant, latch owner, address and we; move to CMD.
- CMD: mem_cmd_valid=1 with the latched fields. On mem_cmd_ready, pulse the owner's req_ready, then go to RDATA (we=0) or WDATA (we=1).
- RDATA:
  - Each mem_rdata_valid is forwarded combinationally to the owner only (zero latency) and increments the beat counter.
  - *_rdata_last is asserted on beat LINE_WORDS-1; that beat returns the FSM to IDLE.
- WDATA:
  - mem_wdata_valid=1, mem_wdata=d_wdata, d_wdata_ready=mem_wdata_ready.
  - Each handshake increments the counter. The last handshake pulses d_wr_done and returns to IDLE.
- Beat counter is $clog2(LINE_WORDS) bits, cleared on every grant. Wrap is never reached because the last beat exits the state.
- mem_rdata_valid outside RDATA is ignored; no rdata_valid is produced.
- Requester signals are sampled only at grant. Changes after grant do not affect the in-flight command.
- The I-cache never issues writes; only D may enter WDATA.

## Timing
- Reset values:
  - State IDLE, last_grant=I (so D wins the first tie).
  - All valid, ready and done outputs 0; counters 0; data/address outputs 0.
- Reset mid-transaction: the next cycle is IDLE with all outputs deasserted. The transaction is abandoned, and the memory is reset with the core.
- Request seen in IDLE at cycle t → mem_cmd_valid at t+1. req_ready coincides with the cycle mem_cmd_ready=1.
- One IDLE bubble follows every transaction. Back-to-back lines cost LINE_WORDS + 2 cycles minimum with zero-wait memory.
- Simultaneous I and D requests with last_grant=D → I granted; D is served next, immediately after I completes.

## Configuration
- MEM_ARB_PERF_EN defined:
  - perf_i_wait increments each cycle i_req_valid=1 and i_req_ready=0; perf_d_wait likewise for D.
  - Both saturate at 2^32-1 and reset to 0.
- MEM_ARB_PERF_EN undefined: both ports and counters are absent; the rest of the behaviour is unchanged.

## Structure
- mips_core_pkg holds:
  - mem_arb_state_t enum {IDLE, CMD, RDATA, WDATA}
  - mem_arb_owner_t enum {OWNER_I, OWNER_D}
- Sub-module mem_arb_rr_picker: 2-way round-robin pick from the two valids and last_grant, purely combinational. The FSM stays in mem_port_arbiter.

## Test plan
- I refill only, addr 0x100, memory returns 0xA0..0xA3 → i_rdata beats 0xA0..0xA3, i_rdata_last on 0xA3, d_rdata_valid never 1.
- D writeback addr 0x200, d_wdata 0x11..0x14, mem_wdata_ready toggling 1/0 → exactly 4 mem beats in order, d_wr_done on the 4th.
- I and D both valid from reset → D granted first, I second. Repeat with both held → grants alternate D, I, D, I.
- mem_cmd_ready held 0 for 5 cycles → mem_cmd_valid and mem_cmd_addr stable, no req_ready until ready rises.
- rst asserted during beat 2 of a D refill → next cycle IDLE, all outputs 0. A fresh I request is then served normally.
- With MEM_ARB_PERF_EN, I waits 7 cycles behind a D line → perf_i_wait=7. Without the macro, the bench compiles without the perf ports.

Source files
------------

// File: rtl/mips_core_pkg.sv
// Shared types for the core's memory-port arbiter.
// ADDR_WIDTH falls back to 32 bits when the build does not define it.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif

package mips_core_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CMD,
        RDATA,
        WDATA
    } mem_arb_state_t;

    typedef enum logic {
        OWNER_I,
        OWNER_D
    } mem_arb_owner_t;

endpackage

// File: rtl/mem_arb_rr_picker.sv
// Two-way round-robin pick between I and D refill/writeback requests.
// Purely combinational; the caller owns the last_grant register.
module mem_arb_rr_picker
    import mips_core_pkg::*;
(
    input  logic           i_vld_i,
    input  logic           i_vld_d,
    input  mem_arb_owner_t i_last,
    output logic           o_any,
    output mem_arb_owner_t o_pick
);

    always_comb begin
        o_any = i_vld_i | i_vld_d;
        if (i_vld_i && i_vld_d)
            o_pick = (i_last == OWNER_I) ? OWNER_D : OWNER_I;
        else if (i_vld_d)
            o_pick = OWNER_D;
        else
            o_pick = OWNER_I;
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Serialises I-cache refills and D-cache refills/writebacks onto one memory port.
// Define MEM_ARB_PERF_EN to add the perf_i_wait / perf_d_wait stall counters.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif

module mem_port_arbiter
    import mips_core_pkg::*;
#(
    parameter int LINE_WORDS = 4,
    parameter int DATA_WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_req_valid,
    input  logic [`ADDR_WIDTH-1:0] i_req_addr,
    output logic                   i_req_ready,
    output logic                   i_rdata_valid,
    output logic [DATA_WIDTH-1:0]  i_rdata,
    output logic                   i_rdata_last,
    input  logic                   d_req_valid,
    input  logic                   d_req_we,
    input  logic [`ADDR_WIDTH-1:0] d_req_addr,
    output logic                   d_req_ready,
    input  logic [DATA_WIDTH-1:0]  d_wdata,
    output logic                   d_wdata_ready,
    output logic                   d_wr_done,
    output logic                   d_rdata_valid,
    output logic [DATA_WIDTH-1:0]  d_rdata,
    output logic                   d_rdata_last,
    output logic                   mem_cmd_valid,
    output logic                   mem_cmd_we,
    output logic [`ADDR_WIDTH-1:0] mem_cmd_addr,
    input  logic                   mem_cmd_ready,
    output logic                   mem_wdata_valid,
    output logic [DATA_WIDTH-1:0]  mem_wdata,
    input  logic                   mem_wdata_ready,
    input  logic                   mem_rdata_valid,
`ifdef MEM_ARB_PERF_EN
    output logic [31:0]            perf_i_wait,
    output logic [31:0]            perf_d_wait,
`endif
    input  logic [DATA_WIDTH-1:0]  mem_rdata
);

    localparam int CW = $clog2(LINE_WORDS);

    mem_arb_state_t         r_state;
    mem_arb_owner_t         r_owner;
    mem_arb_owner_t         r_last;
    logic [`ADDR_WIDTH-1:0] r_addr;
    logic                   r_we;
    logic [CW-1:0]          r_cnt;

    logic                   w_any;
    mem_arb_owner_t         w_pick;
    logic                   w_cmd_hs;
    logic                   w_rd_beat;
    logic                   w_cnt_last;

    mem_arb_rr_picker u_picker (
        .i_vld_i (i_req_valid),
        .i_vld_d (d_req_valid),
        .i_last  (r_last),
        .o_any   (w_any),
        .o_pick  (w_pick)
    );

    assign w_cnt_last = (r_cnt == CW'(LINE_WORDS - 1));
    assign w_cmd_hs   = (r_state == CMD) && mem_cmd_ready;
    assign w_rd_beat  = (r_state == RDATA) && mem_rdata_valid;

    // Requester fields are captured only here; later changes cannot disturb the line.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_owner <= OWNER_I;
            r_last  <= OWNER_I;
            r_addr  <= '0;
            r_we    <= 1'b0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                IDLE: if (w_any) begin
                    r_owner <= w_pick;
                    r_last  <= w_pick;
                    r_addr  <= (w_pick == OWNER_D) ? d_req_addr : i_req_addr;
                    r_we    <= (w_pick == OWNER_D) && d_req_we;
                    r_cnt   <= '0;
                    r_state <= CMD;
                end
                CMD: if (mem_cmd_ready)
                    r_state <= r_we ? WDATA : RDATA;
                RDATA: if (mem_rdata_valid) begin
                    r_cnt <= r_cnt + CW'(1);
                    if (w_cnt_last) r_state <= IDLE;
                end
                WDATA: if (mem_wdata_ready) begin
                    r_cnt <= r_cnt + CW'(1);
                    if (w_cnt_last) r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign mem_cmd_valid   = (r_state == CMD);
    assign mem_cmd_we      = (r_state == CMD) && r_we;
    assign mem_cmd_addr    = r_addr;
    assign i_req_ready     = w_cmd_hs && (r_owner == OWNER_I);
    assign d_req_ready     = w_cmd_hs && (r_owner == OWNER_D);

    // Read beats go straight through to the owner only, with no added latency.
    assign i_rdata_valid   = w_rd_beat && (r_owner == OWNER_I);
    assign d_rdata_valid   = w_rd_beat && (r_owner == OWNER_D);
    assign i_rdata         = i_rdata_valid ? mem_rdata : '0;
    assign d_rdata         = d_rdata_valid ? mem_rdata : '0;
    assign i_rdata_last    = i_rdata_valid && w_cnt_last;
    assign d_rdata_last    = d_rdata_valid && w_cnt_last;

    assign mem_wdata_valid = (r_state == WDATA);
    assign mem_wdata       = mem_wdata_valid ? d_wdata : '0;
    assign d_wdata_ready   = mem_wdata_valid && mem_wdata_ready;
    assign d_wr_done       = d_wdata_ready && w_cnt_last;

`ifdef MEM_ARB_PERF_EN
    logic [31:0] r_perf_i;
    logic [31:0] r_perf_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_perf_i <= '0;
            r_perf_d <= '0;
        end else begin
            if (i_req_valid && !i_req_ready && (r_perf_i != '1)) r_perf_i <= r_perf_i + 32'd1;
            if (d_req_valid && !d_req_ready && (r_perf_d != '1)) r_perf_d <= r_perf_d + 32'd1;
        end
    end

    assign perf_i_wait = r_perf_i;
    assign perf_d_wait = r_perf_d;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomised bench for mem_port_arbiter against a transaction-level model of the port.
// Perf counters are checked only when MEM_ARB_PERF_EN is defined.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif

module tb_mem_port_arbiter;

    localparam int LW = 4;
    localparam int DW = 32;
    localparam int AW = `ADDR_WIDTH;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_req_valid, i_req_ready, i_rdata_valid, i_rdata_last;
    logic [AW-1:0] i_req_addr;
    logic [DW-1:0] i_rdata;
    logic          d_req_valid, d_req_we, d_req_ready, d_wdata_ready, d_wr_done;
    logic          d_rdata_valid, d_rdata_last;
    logic [AW-1:0] d_req_addr;
    logic [DW-1:0] d_wdata, d_rdata;
    logic          mem_cmd_valid, mem_cmd_we, mem_cmd_ready;
    logic [AW-1:0] mem_cmd_addr;
    logic          mem_wdata_valid, mem_wdata_ready, mem_rdata_valid;
    logic [DW-1:0] mem_wdata, mem_rdata;
`ifdef MEM_ARB_PERF_EN
    logic [31:0]   perf_i_wait, perf_d_wait;
`endif

    always #5 clk = ~clk;

    mem_port_arbiter #(.LINE_WORDS(LW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .rst(rst),
        .i_req_valid(i_req_valid), .i_req_addr(i_req_addr), .i_req_ready(i_req_ready),
        .i_rdata_valid(i_rdata_valid), .i_rdata(i_rdata), .i_rdata_last(i_rdata_last),
        .d_req_valid(d_req_valid), .d_req_we(d_req_we), .d_req_addr(d_req_addr),
        .d_req_ready(d_req_ready), .d_wdata(d_wdata), .d_wdata_ready(d_wdata_ready),
        .d_wr_done(d_wr_done), .d_rdata_valid(d_rdata_valid), .d_rdata(d_rdata),
        .d_rdata_last(d_rdata_last),
        .mem_cmd_valid(mem_cmd_valid), .mem_cmd_we(mem_cmd_we), .mem_cmd_addr(mem_cmd_addr),
        .mem_cmd_ready(mem_cmd_ready), .mem_wdata_valid(mem_wdata_valid),
        .mem_wdata(mem_wdata), .mem_wdata_ready(mem_wdata_ready),
        .mem_rdata_valid(mem_rdata_valid),
`ifdef MEM_ARB_PERF_EN
        .perf_i_wait(perf_i_wait), .perf_d_wait(perf_d_wait),
`endif
        .mem_rdata(mem_rdata)
    );

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Port model: phase of the single in-flight line plus the two cache requesters.
    typedef enum int {P_IDLE, P_CMD, P_RD, P_WR} ph_t;
    ph_t           ph = P_IDLE;
    int            m_owner = 0, m_last = 0, m_beat = 0;   // owner 0 = I, 1 = D
    logic [AW-1:0] m_addr = '0;
    bit            m_we = 0;
    int            i_st = 0, d_st = 0, d_idx = 0;         // 0 idle, 1 requesting, 2 line in flight
    logic [AW-1:0] i_a = '0, d_a = '0;
    bit            d_w = 0;
    logic [DW-1:0] d_words [LW];
    logic [DW-1:0] mem [int];

    int            p_req_i = 0, p_req_d = 0, p_cmd = 100, p_rd = 100, p_wr = 100, p_we = 0;
    bit            wtog_mode = 0, wtog = 1, kick_i = 0, kick_d = 0;
    logic [AW-1:0] fix_i_a = '0, fix_d_a = '0;
    bit            fix_d_we = 0;
    int            cmd_hold = 0;
    bit            rst_req = 1, post_rst = 0, chk_perf7 = 0;
    int            m_pi = 0, m_pd = 0;
    int            lines_done = 0, cmd_cycles = 0, wr_beats = 0, done_cnt = 0;
    int            obs_q [$];

    function automatic logic [AW-1:0] rand_line();
        return AW'($urandom_range(0, 31) * (LW * 4));
    endfunction

    function automatic logic [DW-1:0] memword(input logic [AW-1:0] a, input int b);
        int key = int'(a >> 2) + b;
        if (mem.exists(key)) return mem[key];
        return DW'(32'hC0DE_0000 ^ (key * 32'h9E37));
    endfunction

    task automatic drive();
        bit garb_i, garb_d;
        if (!rst_req) begin
            if (i_st == 0 && (kick_i || $urandom_range(0, 99) < p_req_i)) begin
                i_st = 1;
                i_a = kick_i ? fix_i_a : rand_line();
                kick_i = 0;
            end
            if (d_st == 0 && (kick_d || $urandom_range(0, 99) < p_req_d)) begin
                d_st = 1;
                d_a = kick_d ? fix_d_a : rand_line();
                d_w = kick_d ? fix_d_we : ($urandom_range(0, 99) < p_we);
                for (int k = 0; k < LW; k++) d_words[k] = kick_d ? DW'(32'h11 + k) : DW'($urandom);
                d_idx = 0;
                kick_d = 0;
            end
        end
        // Once granted, a requester's fields may wander; the DUT must ignore them.
        garb_i = (ph == P_CMD) && (m_owner == 0) && ($urandom_range(0, 1) == 1);
        garb_d = (ph == P_CMD) && (m_owner == 1) && ($urandom_range(0, 1) == 1);
        rst             = rst_req;
        i_req_valid     = (i_st == 1);
        i_req_addr      = (i_st == 1 && !garb_i) ? i_a : AW'($urandom);
        d_req_valid     = (d_st == 1);
        d_req_addr      = (d_st == 1 && !garb_d) ? d_a : AW'($urandom);
        d_req_we        = garb_d ? !d_w : d_w;
        d_wdata         = d_words[d_idx];
        mem_cmd_ready   = (cmd_hold > 0) ? 1'b0 : ($urandom_range(0, 99) < p_cmd);
        mem_rdata_valid = ($urandom_range(0, 99) < p_rd);
        mem_rdata       = (ph == P_RD) ? memword(m_addr, m_beat) : DW'($urandom);
        mem_wdata_ready = wtog_mode ? wtog : ($urandom_range(0, 99) < p_wr);
    endtask

    task automatic eval();
        bit exp_ir, exp_dr;
        logic [DW-1:0] exp_w;
        if (rst_req) begin
            ph = P_IDLE; m_last = 0; i_st = 0; d_st = 0; d_idx = 0;
            m_pi = 0; m_pd = 0; cmd_hold = 0; post_rst = 1;
            return;
        end
        if (post_rst) begin
            post_rst = 0;
            chk("rst_cmd", {mem_cmd_valid, mem_cmd_we, i_req_ready, d_req_ready}, 0);
            chk("rst_cmd_addr", mem_cmd_addr, 0);
            chk("rst_rvalid", {i_rdata_valid, i_rdata_last, d_rdata_valid, d_rdata_last}, 0);
            chk("rst_rdata", {i_rdata, d_rdata}, 0);
            chk("rst_wr", {mem_wdata_valid, d_wdata_ready, d_wr_done}, 0);
            chk("rst_wdata", mem_wdata, 0);
        end
`ifdef MEM_ARB_PERF_EN
        chk("perf_i_wait", perf_i_wait, m_pi);
        chk("perf_d_wait", perf_d_wait, m_pd);
        if (chk_perf7 && i_req_ready) begin
            chk("perf_i_wait_behind_d", perf_i_wait, 7);
            chk_perf7 = 0;
        end
`endif
        if (i_req_ready) obs_q.push_back(0);
        if (d_req_ready) obs_q.push_back(1);
        if (mem_cmd_valid) cmd_cycles++;
        if (mem_wdata_valid && mem_wdata_ready) wr_beats++;
        if (d_wr_done) done_cnt++;

        exp_ir = (ph == P_CMD) && (m_owner == 0) && mem_cmd_ready;
        exp_dr = (ph == P_CMD) && (m_owner == 1) && mem_cmd_ready;
        if (ph != P_CMD) chk("no_cmd", {mem_cmd_valid, i_req_ready, d_req_ready}, 0);
        if (ph != P_RD)  chk("no_rdata", {i_rdata_valid, d_rdata_valid, i_rdata_last, d_rdata_last}, 0);
        if (ph != P_WR)  chk("no_wdata", {mem_wdata_valid, d_wdata_ready, d_wr_done}, 0);

        case (ph)
            P_IDLE: if (i_req_valid || d_req_valid) begin
                if (i_req_valid && d_req_valid) m_owner = 1 - m_last;
                else m_owner = d_req_valid ? 1 : 0;
                m_last = m_owner;
                m_addr = m_owner ? d_a : i_a;
                m_we   = m_owner ? d_w : 1'b0;
                ph     = P_CMD;
            end
            P_CMD: begin
                chk("cmd_valid", mem_cmd_valid, 1);
                chk("cmd_addr", mem_cmd_addr, m_addr);
                chk("cmd_we", mem_cmd_we, m_we);
                chk("i_req_ready", i_req_ready, exp_ir);
                chk("d_req_ready", d_req_ready, exp_dr);
                if (cmd_hold > 0) cmd_hold--;
                if (mem_cmd_ready) begin
                    if (m_owner == 1) d_st = 2; else i_st = 2;
                    m_beat = 0;
                    ph = m_we ? P_WR : P_RD;
                end
            end
            P_RD: begin
                chk("i_rdata_valid", i_rdata_valid, mem_rdata_valid && m_owner == 0);
                chk("d_rdata_valid", d_rdata_valid, mem_rdata_valid && m_owner == 1);
                if (mem_rdata_valid) begin
                    exp_w = memword(m_addr, m_beat);
                    if (m_owner == 0) begin
                        chk("i_rdata", i_rdata, exp_w);
                        chk("i_rdata_last", i_rdata_last, m_beat == LW - 1);
                    end else begin
                        chk("d_rdata", d_rdata, exp_w);
                        chk("d_rdata_last", d_rdata_last, m_beat == LW - 1);
                    end
                    m_beat++;
                    if (m_beat == LW) begin
                        ph = P_IDLE;
                        lines_done++;
                        if (m_owner == 1) d_st = 0; else i_st = 0;
                    end
                end else begin
                    chk("rd_last_idle", {i_rdata_last, d_rdata_last}, 0);
                end
            end
            P_WR: begin
                chk("mem_wdata_valid", mem_wdata_valid, 1);
                chk("mem_wdata", mem_wdata, d_words[m_beat]);
                chk("d_wdata_ready", d_wdata_ready, mem_wdata_ready);
                chk("d_wr_done", d_wr_done, mem_wdata_ready && m_beat == LW - 1);
                if (mem_wdata_ready) begin
                    mem[int'(m_addr >> 2) + m_beat] = d_words[m_beat];
                    m_beat++;
                    d_idx = m_beat;
                    if (m_beat == LW) begin
                        ph = P_IDLE; d_st = 0; d_idx = 0; lines_done++;
                    end
                end
                if (wtog_mode) wtog = !wtog;
            end
            default: ph = P_IDLE;
        endcase

        if (i_req_valid && !exp_ir) m_pi++;
        if (d_req_valid && !exp_dr) m_pd++;
    endtask

    task automatic step();
        drive();
        @(negedge clk);
        eval();
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string tag);
        bit ok;
        p_req_i = 0; p_req_d = 0;
        for (int k = 0; k < 300 && !(ph == P_IDLE && i_st == 0 && d_st == 0); k++) step();
        ok = (ph == P_IDLE && i_st == 0 && d_st == 0);
        chk(tag, ok, 1);
    endtask

    initial begin
        int base;
        for (int k = 0; k < LW; k++) begin
            d_words[k] = '0;
            mem[(32'h100 >> 2) + k] = DW'(32'hA0 + k);
        end
        drive();
        @(posedge clk); #1;
        repeat (3) step();
        rst_req = 0;
        step();

        // Both caches ask on the same cycle out of reset: D first, then I.
        obs_q.delete();
        fix_i_a = 'h100; fix_d_a = 'h300; fix_d_we = 0;
        kick_i = 1; kick_d = 1; chk_perf7 = 1;
        step();
        drain("tie_done");
        chk("tie_grants", obs_q.size(), 2);
        if (obs_q.size() >= 2) begin
            chk("tie_first_d", obs_q[0], 1);
            chk("tie_second_i", obs_q[1], 0);
        end

        // Writeback with memory accepting every other cycle.
        wr_beats = 0; done_cnt = 0;
        fix_d_a = 'h200; fix_d_we = 1; wtog_mode = 1; wtog = 1; kick_d = 1;
        step();
        drain("wb_done");
        chk("wb_beats", wr_beats, 4);
        chk("wb_done_pulses", done_cnt, 1);
        wtog_mode = 0;

        // Command held off by memory for five cycles.
        cmd_cycles = 0; cmd_hold = 5; fix_i_a = 'h140; kick_i = 1;
        step();
        drain("hold_done");
        chk("hold_cmd_cycles", cmd_cycles, 6);

        // Both requesters always hungry: grants must alternate.
        obs_q.delete();
        p_req_i = 100; p_req_d = 100; p_we = 50;
        repeat (60) step();
        drain("alt_done");
        chk("alt_enough", obs_q.size() >= 6, 1);
        for (int k = 1; k < obs_q.size(); k++) chk("alt_grant", obs_q[k], 1 - obs_q[k-1]);

        // Reset in the middle of a D refill, then a normal I refill.
        fix_d_a = 'h180; fix_d_we = 0; kick_d = 1;
        for (int k = 0; k < 50 && !(ph == P_RD && m_owner == 1 && m_beat == 2); k++) step();
        chk("mid_rst_reached", (ph == P_RD && m_owner == 1 && m_beat == 2), 1);
        rst_req = 1;
        step();
        rst_req = 0;
        step();
        base = lines_done;
        fix_i_a = 'h100; kick_i = 1;
        step();
        drain("post_rst_done");
        chk("post_rst_line", lines_done - base, 1);

        // Random traffic with random memory stalls.
        p_cmd = 50; p_rd = 60; p_wr = 60; p_we = 50;
        p_req_i = 30; p_req_d = 30;
        repeat (3000) step();
        p_cmd = 100; p_rd = 100; p_wr = 100;
        drain("rand_done");
        chk("rand_lines", lines_done > base + 50, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
